cascade_counter: RTL and testbench
==================================

CASCADE_COUNTER -- requirements
Module: cascade_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 2: number of cascaded digit stages.
REQ-002 SHALL have parameter DIGIT_W, default 4: width of each digit in bits.
REQ-003 SHALL have parameter MODULUS, default 16: count states per digit; 10 gives BCD; legal range 2..2**DIGIT_W.
REQ-004 SHALL have port clock, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port clear, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port load, input, 1 bit: parallel load strobe.
REQ-007 SHALL have port data, input, DIGITS*DIGIT_W bits: load value; digit 0 is in the LSBs.
REQ-008 SHALL have port start_stop, input, 1 bit: count enable; 1 = run, 0 = hold.
REQ-009 SHALL have port up_down, input, 1 bit: count direction; 1 = up, 0 = down.
REQ-010 SHALL have port count, output, DIGITS*DIGIT_W bits: current value; digit 0 is in the LSBs.
REQ-011 SHALL have port tc, output, 1 bit: terminal count, combinational.
REQ-012 SHALL have port wrapped, output, 1 bit: sticky wrap flag; present only with the macro in REQ-025.

Function
REQ-013 SHALL apply priority per rising edge: clear, then load, then count, then hold.
REQ-014 SHALL load digit i from data slice i on load=1 (no clear), with no count that cycle; a slice >= MODULUS loads MODULUS-1.
REQ-015 SHALL hold every digit when start_stop=0 and no clear or load.
REQ-016 SHALL step digit 0 by +1 (up) or -1 (down), modulo MODULUS, on each enabled cycle.
REQ-017 SHALL step digit i>0 only when start_stop=1 and every lower digit is terminal.
REQ-018 SHALL treat a digit as terminal at MODULUS-1 when counting up and at 0 when counting down.
REQ-019 SHALL form the digit enable chain combinationally, so all digits update on the same edge; no ripple clocks and no extra latency.
REQ-020 SHALL drive tc=1 exactly when start_stop=1 and all digits are terminal for the current up_down.
REQ-021 SHALL wrap the full count from all-(MODULUS-1) to all-0 when counting up, and from all-0 to all-(MODULUS-1) when counting down.
REQ-022 SHALL take effect on the next enabled edge when up_down changes, with no lost or duplicated step.

Reset
REQ-023 SHALL drive count=0, and wrapped=0 when present, on the edge after clear=1, regardless of load or start_stop.
REQ-024 SHALL force count=0 on the next edge when clear asserts mid-count; counting resumes from 0 on the first enabled edge after clear deasserts.

Configuration
REQ-025 SHALL compile in port wrapped and its flag register only when CASCADE_COUNTER_WRAP_FLAG_EN is defined.
- Flag set on any edge where tc=1 and the count steps.
- Flag cleared by clear or load.
- Without the macro: no wrapped port and no flag register; all other behaviour unchanged.

Structure
REQ-026 SHALL place in shared package cascade_counter_pkg:
- default DIGIT_W and MODULUS constants;
- constant BCD_MODULUS=10;
- the up/down direction encoding constants.
REQ-027 SHALL implement each digit as sub-module counter_digit, instantiated DIGITS times in a generate loop.
- counter_digit ports: clock, clear, load, data, enable, up_down, count, term.

Verification (DIGITS=2, MODULUS=10 unless stated)
REQ-028 SHALL cover: load data=0x39, up, start_stop=1, one edge -> count=0x40; tc=0 throughout.
REQ-029 SHALL cover: count=0x99, up, start_stop=1 -> tc=1 before the edge, count=0x00 after it, wrapped=1 (macro on).
REQ-030 SHALL cover: count=0x00, down, one edge -> count=0x99; tc=1 before the edge.
REQ-031 SHALL cover: clear=1 and load=1 together with data=0x55 -> count=0x00 and wrapped=0.
REQ-032 SHALL cover: load data=0xAF -> count=0x99; then start_stop=0 for 5 edges -> count stays 0x99, tc=0.
REQ-033 SHALL cover: DIGITS=3, MODULUS=16, count=0x0FF, up, one edge -> count=0x100.

Source files
------------

// File: rtl/cascade_counter_pkg.sv
// Shared constants for the cascaded up/down digit counter.
package cascade_counter_pkg;

    localparam int unsigned DEFAULT_DIGIT_W = 4;
    localparam int unsigned DEFAULT_MODULUS = 16;
    localparam int unsigned BCD_MODULUS     = 10;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/cascade_counter_digit.sv
// One modulo-MODULUS digit stage with synchronous clear, clamped parallel load and
// a terminal flag that feeds the enable of the next stage.
module counter_digit
    import cascade_counter_pkg::*;
#(
    parameter int unsigned DIGIT_W = DEFAULT_DIGIT_W,
    parameter int unsigned MODULUS = DEFAULT_MODULUS
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               load,
    input  logic [DIGIT_W-1:0] data,
    input  logic               enable,
    input  logic               up_down,
    output logic [DIGIT_W-1:0] count,
    output logic               term
);

    localparam int unsigned        MaxVal   = MODULUS - 1;
    localparam logic [DIGIT_W-1:0] MaxDigit = MaxVal[DIGIT_W-1:0];

    logic [DIGIT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            // Out-of-range load values saturate to the largest legal digit.
            count_d = (data > MaxDigit) ? MaxDigit : data;
        end else if (enable) begin
            if (up_down == DIR_UP) begin
                count_d = (count_q == MaxDigit) ? '0 : count_q + DIGIT_W'(1);
            end else begin
                count_d = (count_q == '0) ? MaxDigit : count_q - DIGIT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign term  = (up_down == DIR_UP) ? (count_q == MaxDigit) : (count_q == '0);

endmodule

// File: rtl/cascade_counter.sv
// Synchronous cascaded multi-digit up/down counter. Define CASCADE_COUNTER_WRAP_FLAG_EN
// to add the sticky "wrapped" output and its flag register.
module cascade_counter
    import cascade_counter_pkg::*;
#(
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned DIGIT_W = DEFAULT_DIGIT_W,
    parameter int unsigned MODULUS = DEFAULT_MODULUS
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic                      load,
    input  logic [DIGITS*DIGIT_W-1:0] data,
    input  logic                      start_stop,
    input  logic                      up_down,
    output logic [DIGITS*DIGIT_W-1:0] count,
`ifdef CASCADE_COUNTER_WRAP_FLAG_EN
    output logic                      wrapped,
`endif
    output logic                      tc
);

    logic [DIGITS-1:0] term;
    logic [DIGITS:0]   en;

    // Combinational carry chain: digit i steps when all lower digits are terminal.
    always_comb begin
        en    = '0;
        en[0] = start_stop;
        for (int i = 0; i < DIGITS; i++) begin
            en[i+1] = en[i] & term[i];
        end
    end

    assign tc = en[DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        counter_digit #(
            .DIGIT_W(DIGIT_W),
            .MODULUS(MODULUS)
        ) u_digit (
            .clock  (clock),
            .clear  (clear),
            .load   (load),
            .data   (data[g*DIGIT_W +: DIGIT_W]),
            .enable (en[g]),
            .up_down(up_down),
            .count  (count[g*DIGIT_W +: DIGIT_W]),
            .term   (term[g])
        );
    end

`ifdef CASCADE_COUNTER_WRAP_FLAG_EN
    logic wrapped_q, wrapped_d;

    always_comb begin
        wrapped_d = wrapped_q;
        if (load) begin
            wrapped_d = 1'b0;
        end else if (tc) begin
            wrapped_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            wrapped_q <= 1'b0;
        end else begin
            wrapped_q <= wrapped_d;
        end
    end

    assign wrapped = wrapped_q;
`endif

endmodule

// File: tb/tb_cascade_counter.sv
// Scoreboard bench: BCD 2-digit and hex 3-digit counters driven in lockstep against an
// integer-valued reference model.
module tb_cascade_counter;

    logic        clk = 1'b0;
    logic        clear, load, start_stop, up_down;
    logic [7:0]  data_a;
    logic [11:0] data_b;
    logic [7:0]  count_a;
    logic [11:0] count_b;
    logic        tc_a, tc_b;
`ifdef CASCADE_COUNTER_WRAP_FLAG_EN
    logic        wrapped_a, wrapped_b;
`endif

    always #5 clk = ~clk;

    cascade_counter #(.DIGITS(2), .DIGIT_W(4), .MODULUS(10)) u_dut_a (
        .clock     (clk),
        .clear     (clear),
        .load      (load),
        .data      (data_a),
        .start_stop(start_stop),
        .up_down   (up_down),
        .count     (count_a),
`ifdef CASCADE_COUNTER_WRAP_FLAG_EN
        .wrapped   (wrapped_a),
`endif
        .tc        (tc_a)
    );

    cascade_counter #(.DIGITS(3), .DIGIT_W(4), .MODULUS(16)) u_dut_b (
        .clock     (clk),
        .clear     (clear),
        .load      (load),
        .data      (data_b),
        .start_stop(start_stop),
        .up_down   (up_down),
        .count     (count_b),
`ifdef CASCADE_COUNTER_WRAP_FLAG_EN
        .wrapped   (wrapped_b),
`endif
        .tc        (tc_b)
    );

    typedef struct {
        logic [7:0]  ca;
        logic        tca;
        logic        wa;
        logic [11:0] cb;
        logic        tcb;
        logic        wb;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model: whole counter value as a plain integer modulo MODULUS**DIGITS.
    int unsigned va, vb;
    logic        wa_m, wb_m;
    localparam int unsigned NA = 100;
    localparam int unsigned NB = 4096;

    function automatic logic [11:0] to_bus(int unsigned v, int unsigned d, int unsigned m);
        logic [11:0] r;
        r = '0;
        for (int i = 0; i < d; i++) begin
            r = r | (12'(v % m) << (4 * i));
            v = v / m;
        end
        return r;
    endfunction

    function automatic int unsigned from_data(logic [11:0] dat, int unsigned d,
                                              int unsigned m);
        int unsigned v, w, s;
        v = 0;
        w = 1;
        for (int i = 0; i < d; i++) begin
            s = 32'((dat >> (4 * i)) & 12'hF);
            if (s >= m) s = m - 1;
            v = v + s * w;
            w = w * m;
        end
        return v;
    endfunction

    task automatic step(input logic c, input logic l, input logic [7:0] da,
                        input logic [11:0] db, input logic ss, input logic ud);
        exp_t e;
        @(posedge clk);
        #1;
        clear      = c;
        load       = l;
        data_a     = da;
        data_b     = db;
        start_stop = ss;
        up_down    = ud;
        e.ca  = 8'(to_bus(va, 2, 10));
        e.tca = ss && (ud ? (va == NA - 1) : (va == 0));
        e.wa  = wa_m;
        e.cb  = to_bus(vb, 3, 16);
        e.tcb = ss && (ud ? (vb == NB - 1) : (vb == 0));
        e.wb  = wb_m;
        sb_q.push_back(e);
        if (c) begin
            va = 0; vb = 0; wa_m = 1'b0; wb_m = 1'b0;
        end else if (l) begin
            va = from_data({4'h0, da}, 2, 10);
            vb = from_data(db, 3, 16);
            wa_m = 1'b0; wb_m = 1'b0;
        end else if (ss) begin
            if (e.tca) wa_m = 1'b1;
            if (e.tcb) wb_m = 1'b1;
            va = ud ? (va + 1) % NA : (va + NA - 1) % NA;
            vb = ud ? (vb + 1) % NB : (vb + NB - 1) % NB;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: DUT state is stable at the falling edge, so each pending entry is compared there.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("count_a", 32'(count_a), 32'(e.ca));
                check("tc_a", 32'(tc_a), 32'(e.tca));
                check("count_b", 32'(count_b), 32'(e.cb));
                check("tc_b", 32'(tc_b), 32'(e.tcb));
`ifdef CASCADE_COUNTER_WRAP_FLAG_EN
                check("wrapped_a", 32'(wrapped_a), 32'(e.wa));
                check("wrapped_b", 32'(wrapped_b), 32'(e.wb));
`endif
            end
        end
    end

    initial begin
        clear = 1'b1; load = 1'b0; start_stop = 1'b1; up_down = 1'b1;
        data_a = '0; data_b = '0;
        repeat (2) @(posedge clk);
        va = 0; vb = 0; wa_m = 1'b0; wb_m = 1'b0;

        // Reset state with run enabled still checks as zero.
        step(1, 1, 8'h77, 12'h777, 1, 1);
        step(0, 0, 8'h00, 12'h000, 0, 1);

        // Load 0x39, one up step -> 0x40.
        step(0, 1, 8'h39, 12'h0FF, 0, 1);
        step(0, 0, 8'h00, 12'h000, 1, 1);
        step(0, 0, 8'h00, 12'h000, 0, 1);

        // Full wrap up from 0x99 / 0xFFF.
        step(0, 1, 8'h99, 12'hFFF, 0, 1);
        step(0, 0, 8'h00, 12'h000, 1, 1);
        step(0, 0, 8'h00, 12'h000, 0, 1);

        // Full wrap down from zero.
        step(0, 1, 8'h00, 12'h000, 0, 0);
        step(0, 0, 8'h00, 12'h000, 1, 0);
        step(0, 0, 8'h00, 12'h000, 0, 0);

        // Clear beats load.
        step(0, 0, 8'h00, 12'h000, 1, 1);
        step(1, 1, 8'h55, 12'h555, 1, 1);
        step(0, 0, 8'h00, 12'h000, 0, 1);

        // Clamped load then hold for five edges.
        step(0, 1, 8'hAF, 12'hFAF, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 8'h12, 12'h345, 0, 1);

        // Direction change mid-count.
        step(0, 1, 8'h10, 12'h100, 0, 1);
        step(0, 0, 8'h00, 12'h000, 1, 0);
        step(0, 0, 8'h00, 12'h000, 1, 1);
        step(0, 0, 8'h00, 12'h000, 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
                 8'($urandom), 12'($urandom), ($urandom_range(0, 3) != 0),
                 1'($urandom));
        end

        repeat (4) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
